segment_frame_writer: RTL and testbench
=======================================

Name: segment_frame_writer

Overview:
- Bus master that sequences the 8-digit 7-segment display peripheral for the digital watch.
- On request it snapshots BCD time (hh:mm:ss) and an edit-field select, then encodes the digits to segment patterns.
- It then issues 9 single-byte writes: digit registers 0..7, then the blink-mask register 8.
- Sits between the timekeeping/edit logic and the display slave's write port.

Parameters:
SEG_ACTIVE_LOW, 1, when 1 every pattern byte (including blank, dash and dp) is bit-inverted before writing
BLANK_LEADING_ZERO, 1, when 1 and hours tens nibble == 0, digit 0 is written as blank
SEP_CODE, 8'h40, active-high separator pattern for digits 2 and 5 (default dash)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
update  in  1  frame request pulse/level, sampled each clk
hours_bcd  in  8  [7:4] tens, [3:0] units
minutes_bcd  in  8  BCD
seconds_bcd  in  8  BCD
blink_sel  in  2  0 none, 1 hours, 2 minutes, 3 seconds
busy  out  1  high while a frame is in progress
done  out  1  one-cycle pulse after the register-8 write is accepted
master_address  out  4  display register index
master_write  out  1  write strobe
master_writedata  out  8  segment pattern / blink mask
master_waitrequest  in  1  slave stall; a write is accepted on a clk edge with master_write=1 and master_waitrequest=0

Behaviour:
- Reset (async) value: state IDLE; busy, done, master_write = 0; master_address = 0; master_writedata = 0; pending = 0. Reset mid-frame drops master_write immediately, and no further writes are issued.
- State machine:
  - IDLE: update=1 at edge -> LOAD.
  - LOAD (1 cycle): snapshot all inputs into frame registers, index = 0 -> WRITE.
  - WRITE: drive address = index, data = frame[index], write = 1. On accept: index 8 -> DONE, otherwise index+1 and stay in WRITE.
  - DONE (1 cycle): done = 1. Then pending ? LOAD : IDLE; pending is cleared on entering LOAD.
- busy = (state != IDLE), registered.
- Frame content:
  - idx0 = hours tens, idx1 = hours units, idx2 = SEP, idx3 = minutes tens, idx4 = minutes units, idx5 = SEP, idx6 = seconds tens, idx7 = seconds units.
  - idx8 = blink mask: 00000000 / 00000011 / 00011000 / 11000000 for blink_sel 0/1/2/3.
  - Bit i of the mask blinks digit i. The mask is never inverted.
- Encoding (active-high, bit7 = dp = 0, gfedcba):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Nibble A..F -> 79 ('E').
  - Blank = 00.
- Timing: update sampled at edge k -> LOAD at k+1, first write at k+2. With no waitrequest, writes are accepted at edges k+2..k+10 (9 consecutive cycles) and done is high for cycle k+10..k+11.
- While master_waitrequest=1: address, data and write are held stable, and index does not advance.
- update asserted in LOAD/WRITE/DONE sets pending. Multiple requests collapse to one re-run, which re-snapshots the then-current inputs. A held-high update yields back-to-back frames.
- Input changes after LOAD do not affect the frame in flight (frame coherency).
- Never writes addresses 9..15. Each frame writes every register exactly once, in ascending order.

Test Plan:
- Active-low default, no stall: hours=0x12, min=0x34, sec=0x56, blink_sel=0, update pulse -> 9 writes addr 0..8, data F9,A4,BF,B0,99,BF,92,82,00. master_write high 9 consecutive cycles; done pulse one cycle after addr 8 accepted; busy then 0.
- Leading-zero blanking + blink: hours=0x07, blink_sel=2 -> addr0 data FF (blank inverted), addr1 F8, addr8 data 0x18.
- Stalls: master_waitrequest high 3 cycles on addr 4 -> addr/data/write held constant 4 cycles, no skipped or duplicated address, total 12 write cycles.
- Coalescing: two update pulses during frame, inputs changed to sec=0x59 mid-frame -> current frame keeps 0x56. Exactly one follow-up frame with sec digits 92 and 90, then IDLE.
- Invalid BCD: minutes=0x3C -> addr4 data 86 ('E' inverted); SEG_ACTIVE_LOW=0 instance, hours=0x08 -> addr0 00, addr1 7F.
- Async reset asserted while waiting on addr 5 -> master_write, busy, done = 0 immediately; after release, no writes until next update.

Source files
------------

// File: rtl/segment_frame_writer.sv
// segment_frame_writer: bus master that writes one 7-segment frame to the display.
// It snapshots BCD hh:mm:ss plus the edit-field select, encodes the digits, and
// issues 9 single-byte writes: digit registers 0..7, then the blink mask at register 8.
//
// state | meaning
// IDLE  | waiting for an update request
// LOAD  | snapshot inputs into the frame registers, present the first write
// WRITE | drive frame[index] to register index; step forward on each accept
// DONE  | one-cycle done pulse, then re-run if a request arrived meanwhile
module segment_frame_writer #(
  parameter bit         SEG_ACTIVE_LOW     = 1'b1,
  parameter bit         BLANK_LEADING_ZERO = 1'b1,
  parameter logic [7:0] SEP_CODE           = 8'h40
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_update,
  input  logic [7:0] i_hours_bcd,
  input  logic [7:0] i_minutes_bcd,
  input  logic [7:0] i_seconds_bcd,
  input  logic [1:0] i_blink_sel,
  output logic       o_busy,
  output logic       o_done,
  output logic [3:0] o_master_address,
  output logic       o_master_write,
  output logic [7:0] o_master_writedata,
  input  logic       i_master_waitrequest
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  state_t          r_state;
  logic [8:0][7:0] r_frame;
  logic [3:0]      r_index;
  logic            r_pending;

  logic [8:0][7:0] w_snap;
  logic [3:0]      w_next_index;
  logic            w_accept;

  // Active-high gfedcba pattern; any non-decimal nibble shows 'E'.
  function automatic logic [7:0] f_seg(input logic [3:0] nib);
    case (nib)
      4'd0:    f_seg = 8'h3F;
      4'd1:    f_seg = 8'h06;
      4'd2:    f_seg = 8'h5B;
      4'd3:    f_seg = 8'h4F;
      4'd4:    f_seg = 8'h66;
      4'd5:    f_seg = 8'h6D;
      4'd6:    f_seg = 8'h7D;
      4'd7:    f_seg = 8'h07;
      4'd8:    f_seg = 8'h7F;
      4'd9:    f_seg = 8'h6F;
      default: f_seg = 8'h79;
    endcase
  endfunction

  // Panel polarity applies to every digit byte, blank and separator included.
  function automatic logic [7:0] f_pol(input logic [7:0] pat);
    f_pol = SEG_ACTIVE_LOW ? ~pat : pat;
  endfunction

  // Frame image computed from the live inputs; only captured in LOAD.
  always_comb begin
    w_snap = '0;
    if (BLANK_LEADING_ZERO && (i_hours_bcd[7:4] == 4'd0))
      w_snap[0] = f_pol(8'h00);
    else
      w_snap[0] = f_pol(f_seg(i_hours_bcd[7:4]));
    w_snap[1] = f_pol(f_seg(i_hours_bcd[3:0]));
    w_snap[2] = f_pol(SEP_CODE);
    w_snap[3] = f_pol(f_seg(i_minutes_bcd[7:4]));
    w_snap[4] = f_pol(f_seg(i_minutes_bcd[3:0]));
    w_snap[5] = f_pol(SEP_CODE);
    w_snap[6] = f_pol(f_seg(i_seconds_bcd[7:4]));
    w_snap[7] = f_pol(f_seg(i_seconds_bcd[3:0]));
    // Blink mask addresses digit positions directly and is never inverted.
    case (i_blink_sel)
      2'd1:    w_snap[8] = 8'b0000_0011;
      2'd2:    w_snap[8] = 8'b0001_1000;
      2'd3:    w_snap[8] = 8'b1100_0000;
      default: w_snap[8] = 8'b0000_0000;
    endcase
  end

  assign w_accept     = o_master_write & ~i_master_waitrequest;
  assign w_next_index = r_index + 4'd1;

  // Frame sequencer with registered bus and status outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state            <= S_IDLE;
      r_frame            <= '0;
      r_index            <= '0;
      r_pending          <= 1'b0;
      o_busy             <= 1'b0;
      o_done             <= 1'b0;
      o_master_address   <= '0;
      o_master_write     <= 1'b0;
      o_master_writedata <= '0;
    end else begin
      o_done <= 1'b0;
      // Requests during a frame collapse into a single re-run.
      if ((r_state != S_IDLE) && i_update)
        r_pending <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_update) begin
            r_state   <= S_LOAD;
            r_pending <= 1'b0;
            o_busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          r_frame            <= w_snap;
          r_index            <= 4'd0;
          o_master_address   <= 4'd0;
          o_master_writedata <= w_snap[0];
          o_master_write     <= 1'b1;
          r_state            <= S_WRITE;
        end
        S_WRITE: begin
          if (w_accept) begin
            if (r_index == 4'd8) begin
              o_master_write <= 1'b0;
              o_done         <= 1'b1;
              r_state        <= S_DONE;
            end else begin
              r_index            <= w_next_index;
              o_master_address   <= w_next_index;
              o_master_writedata <= r_frame[w_next_index];
            end
          end
        end
        S_DONE: begin
          // An update arriving in this very cycle chains straight into the next frame.
          if (r_pending || i_update) begin
            r_state   <= S_LOAD;
            r_pending <= 1'b0;
          end else begin
            r_state <= S_IDLE;
            o_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_segment_frame_writer.sv
// Directed bench for segment_frame_writer: default (active-low) instance plus an
// active-high instance sharing the same stimulus.
module tb_segment_frame_writer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       update = 1'b0;
  logic [7:0] hours = 8'h00, minutes = 8'h00, seconds = 8'h00;
  logic [1:0] blink_sel = 2'd0;
  logic       waitreq = 1'b0;

  logic       busy, done, mwrite;
  logic [3:0] maddr;
  logic [7:0] mdata;
  logic       ah_busy, ah_done, ah_write;
  logic [3:0] ah_addr;
  logic [7:0] ah_data;

  int errors = 0;
  int checks = 0;

  segment_frame_writer dut (
    .i_clk(clk), .i_reset(reset), .i_update(update),
    .i_hours_bcd(hours), .i_minutes_bcd(minutes), .i_seconds_bcd(seconds),
    .i_blink_sel(blink_sel),
    .o_busy(busy), .o_done(done),
    .o_master_address(maddr), .o_master_write(mwrite), .o_master_writedata(mdata),
    .i_master_waitrequest(waitreq)
  );

  segment_frame_writer #(.SEG_ACTIVE_LOW(1'b0)) dut_ah (
    .i_clk(clk), .i_reset(reset), .i_update(update),
    .i_hours_bcd(hours), .i_minutes_bcd(minutes), .i_seconds_bcd(seconds),
    .i_blink_sel(blink_sel),
    .o_busy(ah_busy), .o_done(ah_done),
    .o_master_address(ah_addr), .o_master_write(ah_write), .o_master_writedata(ah_data),
    .i_master_waitrequest(waitreq)
  );

  always #5 clk = ~clk;

  // Write log: {addr, data} of every accepted write, sampled mid-cycle.
  logic [11:0] q_wr[$];
  logic [11:0] q_ah[$];
  int cyc = 0;
  int wr_cycles = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int acc8_cyc = 0;
  int bad_addr = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!reset) begin
      if (mwrite) wr_cycles++;
      if (mwrite && !waitreq) begin
        q_wr.push_back({maddr, mdata});
        if (maddr > 4'd8) bad_addr++;
        if (maddr == 4'd8) acc8_cyc = cyc;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (ah_write && !waitreq) q_ah.push_back({ah_addr, ah_data});
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr_log();
    q_wr.delete();
    q_ah.delete();
    wr_cycles = 0;
    done_cnt  = 0;
  endtask

  task automatic pulse_update();
    @(posedge clk); #1 update = 1'b1;
    @(posedge clk); #1 update = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    @(negedge clk);
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {31'd0, busy}, 32'd0);
  endtask

  task automatic wait_write_addr(input logic [3:0] a, input int budget);
    int n = 0;
    @(negedge clk);
    while (!(mwrite && maddr == a) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("addr_wait_timeout", {31'd0, (mwrite && maddr == a)}, 32'd1);
  endtask

  task automatic chk_entry(input string tag, input int idx, input logic [3:0] a, input logic [7:0] d);
    if (idx < q_wr.size()) chk(tag, {20'd0, q_wr[idx]}, {20'd0, a, d});
    else chk({tag, "_missing"}, idx, q_wr.size());
  endtask

  logic [7:0] exp_a[9];
  initial exp_a = '{8'hF9, 8'hA4, 8'hBF, 8'hB0, 8'h99, 8'hBF, 8'h92, 8'h82, 8'h00};

  initial begin
    // Reset state
    #1;
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_done", {31'd0, done}, 0);
    chk("rst_write", {31'd0, mwrite}, 0);
    chk("rst_addr", {28'd0, maddr}, 0);
    chk("rst_data", {24'd0, mdata}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Basic frame 12:34:56, no stall, exact latency
    hours = 8'h12; minutes = 8'h34; seconds = 8'h56; blink_sel = 2'd0;
    clr_log();
    pulse_update();
    chk("t1_busy_in_load", {31'd0, busy}, 1);
    chk("t1_write_in_load", {31'd0, mwrite}, 0);
    @(posedge clk); #1;
    chk("t1_first_write", {31'd0, mwrite}, 1);
    chk("t1_first_addr", {28'd0, maddr}, 0);
    wait_idle(40);
    chk("t1_nwrites", q_wr.size(), 9);
    for (int i = 0; i < 9; i++) chk_entry("t1_wr", i, i[3:0], exp_a[i]);
    chk("t1_wr_cycles", wr_cycles, 9);
    chk("t1_done_cnt", done_cnt, 1);
    chk("t1_done_after_acc8", done_cyc - acc8_cyc, 1);

    // Leading-zero blanking and minutes blink
    hours = 8'h07; blink_sel = 2'd2;
    clr_log();
    pulse_update();
    wait_idle(40);
    chk("t2_nwrites", q_wr.size(), 9);
    chk_entry("t2_blank", 0, 4'd0, 8'hFF);
    chk_entry("t2_h_units", 1, 4'd1, 8'hF8);
    chk_entry("t2_mask", 8, 4'd8, 8'h18);

    // Three-cycle stall on address 4
    hours = 8'h12; blink_sel = 2'd0;
    clr_log();
    pulse_update();
    wait_write_addr(4'd3, 20);
    @(posedge clk); #1 waitreq = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t3_hold_addr", {28'd0, maddr}, 4);
      chk("t3_hold_data", {24'd0, mdata}, 8'h99);
      chk("t3_hold_write", {31'd0, mwrite}, 1);
      @(posedge clk); #1;
    end
    waitreq = 1'b0;
    wait_idle(40);
    chk("t3_nwrites", q_wr.size(), 9);
    for (int i = 0; i < 9; i++) chk_entry("t3_wr", i, i[3:0], exp_a[i]);
    chk("t3_wr_cycles", wr_cycles, 12);

    // Request coalescing and frame coherency
    clr_log();
    pulse_update();
    wait_write_addr(4'd2, 20);
    pulse_update();
    seconds = 8'h59;
    pulse_update();
    wait_idle(80);
    chk("t4_nwrites", q_wr.size(), 18);
    chk_entry("t4_f1_sec_t", 6, 4'd6, 8'h92);
    chk_entry("t4_f1_sec_u", 7, 4'd7, 8'h82);
    chk_entry("t4_f2_addr0", 9, 4'd0, 8'hF9);
    chk_entry("t4_f2_sec_t", 15, 4'd6, 8'h92);
    chk_entry("t4_f2_sec_u", 16, 4'd7, 8'h90);
    chk("t4_done_cnt", done_cnt, 2);
    repeat (5) @(negedge clk);
    chk("t4_no_third", q_wr.size(), 18);

    // Invalid BCD and active-high instance
    hours = 8'h08; minutes = 8'h3C; seconds = 8'h56;
    clr_log();
    pulse_update();
    wait_idle(40);
    chk_entry("t5_blank_al", 0, 4'd0, 8'hFF);
    chk_entry("t5_eight_al", 1, 4'd1, 8'h80);
    chk_entry("t5_min_t", 3, 4'd3, 8'hB0);
    chk_entry("t5_err_e", 4, 4'd4, 8'h86);
    chk("t5_ah_n", q_ah.size(), 9);
    if (q_ah.size() == 9) begin
      chk("t5_ah_blank", {20'd0, q_ah[0]}, {20'd0, 4'd0, 8'h00});
      chk("t5_ah_eight", {20'd0, q_ah[1]}, {20'd0, 4'd1, 8'h7F});
      chk("t5_ah_sep", {20'd0, q_ah[2]}, {20'd0, 4'd2, 8'h40});
      chk("t5_ah_err_e", {20'd0, q_ah[4]}, {20'd0, 4'd4, 8'h79});
    end

    // Async reset while stalled on address 5
    hours = 8'h12; minutes = 8'h34;
    clr_log();
    pulse_update();
    wait_write_addr(4'd4, 20);
    @(posedge clk); #1 waitreq = 1'b1;
    @(negedge clk);
    chk("t6_stalled_addr", {28'd0, maddr}, 5);
    #1 reset = 1'b1;
    #1;
    chk("t6_rst_write", {31'd0, mwrite}, 0);
    chk("t6_rst_busy", {31'd0, busy}, 0);
    chk("t6_rst_done", {31'd0, done}, 0);
    repeat (2) @(posedge clk);
    #1 waitreq = 1'b0;
    reset = 1'b0;
    clr_log();
    repeat (12) @(negedge clk);
    chk("t6_no_writes", q_wr.size(), 0);
    chk("t6_idle_busy", {31'd0, busy}, 0);
    pulse_update();
    wait_idle(40);
    chk("t6_rerun_n", q_wr.size(), 9);
    chk_entry("t6_rerun_a0", 0, 4'd0, 8'hF9);

    chk("bad_addr", bad_addr, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
